// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle LEGv8 control FSM: opcodes, state
// encoding, ALU_op and alu_src_b encodings, and the opcode-class bundle.
package multicycle_control_pkg;

  localparam int OPC_W = 11;

  localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_LSL  = 11'b11010011011;
  localparam logic [OPC_W-1:0] OP_LSR  = 11'b11010011010;

  // CBZ and B carry immediate bits inside the 11-bit field; the masks keep
  // only the bits that identify the instruction.
  localparam logic [OPC_W-1:0] OP_CBZ      = 11'b10110100000;
  localparam logic [OPC_W-1:0] OP_CBZ_MASK = 11'b11111111000;
  localparam logic [OPC_W-1:0] OP_B        = 11'b00010100000;
  localparam logic [OPC_W-1:0] OP_B_MASK   = 11'b11111100000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_LD = 4'd3,
    S_MEM_ST = 4'd4,
    S_WB_LD  = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_BR_CBZ = 4'd8,
    S_BR_B   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASSB = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_DIMM  = 2'b10,
    SRCB_BROFF = 2'b11
  } src_b_t;

  typedef struct packed {
    logic is_ldur;
    logic is_stur;
    logic is_rtype;
    logic is_cbz;
    logic is_b;
    logic is_illegal;
  } op_class_t;

  function automatic logic op_match(input logic [OPC_W-1:0] op,
                                    input logic [OPC_W-1:0] pat,
                                    input logic [OPC_W-1:0] mask);
    return ((op ^ pat) & mask) == '0;
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_classify.sv
// mc_opcode_classify: combinational opcode decoder feeding the control FSM
// dispatch; exactly one class flag is set for any opcode.
module mc_opcode_classify
  import multicycle_control_pkg::*;
#(
  parameter int OP_WIDTH = 11
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output op_class_t           cls
);

  logic [OPC_W-1:0] w_op;
  logic             w_ldur, w_stur, w_rtype, w_cbz, w_b;

  assign w_op    = opcode[OP_WIDTH-1 -: OPC_W];
  assign w_ldur  = (w_op == OP_LDUR);
  assign w_stur  = (w_op == OP_STUR);
  assign w_rtype = (w_op == OP_ADD) | (w_op == OP_SUB) | (w_op == OP_AND) |
                   (w_op == OP_ORR) | (w_op == OP_LSL) | (w_op == OP_LSR);
  assign w_cbz   = op_match(w_op, OP_CBZ, OP_CBZ_MASK);
  assign w_b     = op_match(w_op, OP_B, OP_B_MASK);

  assign cls.is_ldur    = w_ldur;
  assign cls.is_stur    = w_stur;
  assign cls.is_rtype   = w_rtype;
  assign cls.is_cbz     = w_cbz;
  assign cls.is_b       = w_b;
  assign cls.is_illegal = ~(w_ldur | w_stur | w_rtype | w_cbz | w_b);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle LEGv8 datapath.
// Optional MC_PERF_COUNTERS_EN adds cycle_count / retired_count outputs.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OP_WIDTH  = 11
`ifdef MC_PERF_COUNTERS_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_WIDTH-1:0]  opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [1:0]           ALU_op,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 reg2loc,
  output logic                 pc_write,
  output logic                 pc_source,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic [3:0]           state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count
`endif
);

  state_t    r_state, w_next;
  logic      r_illegal;
  op_class_t w_cls;
  alu_op_t   w_alu_op;
  src_b_t    w_src_b;
  logic      w_src_a, w_reg2loc, w_pc_write, w_pc_source, w_ir_write;
  logic      w_mem_read, w_mem_write, w_i_or_d, w_reg_write, w_mem_to_reg;

  mc_opcode_classify #(.OP_WIDTH(OP_WIDTH)) u_classify (
    .opcode (opcode),
    .cls    (w_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_alu_op     = ALU_ADD;
    w_src_a      = 1'b0;
    w_src_b      = SRCB_REG;
    w_reg2loc    = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_source  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_src_b    = SRCB_FOUR;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_src_b   = SRCB_BROFF;
        w_reg2loc = w_cls.is_stur | w_cls.is_cbz;
        if (w_cls.is_illegal)                  w_next = S_TRAP;
        else if (w_cls.is_ldur | w_cls.is_stur) w_next = S_ADDR;
        else if (w_cls.is_rtype)               w_next = S_EXEC_R;
        else if (w_cls.is_cbz)                 w_next = S_BR_CBZ;
        else if (w_cls.is_b)                   w_next = S_BR_B;
        else                                   w_next = S_TRAP;
      end
      S_ADDR: begin
        w_src_a = 1'b1;
        w_src_b = SRCB_DIMM;
        w_next  = w_cls.is_ldur ? S_MEM_LD : S_MEM_ST;
      end
      S_MEM_LD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (mem_ready) w_next = S_WB_LD;
      end
      S_MEM_ST: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        w_reg2loc   = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_WB_LD: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_EXEC_R: begin
        w_src_a  = 1'b1;
        w_alu_op = ALU_RTYPE;
        w_next   = S_WB_R;
      end
      S_WB_R: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BR_CBZ: begin
        w_reg2loc   = 1'b1;
        w_alu_op    = ALU_PASSB;
        w_pc_source = 1'b1;
        w_pc_write  = zero;
        w_next      = S_FETCH;
      end
      S_BR_B: begin
        w_pc_source = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes and selects fall asynchronously with reset, not at the next edge.
  assign ALU_op     = rst_n ? w_alu_op : ALU_ADD;
  assign alu_src_a  = rst_n & w_src_a;
  assign alu_src_b  = rst_n ? w_src_b : SRCB_REG;
  assign reg2loc    = rst_n & w_reg2loc;
  assign pc_write   = rst_n & w_pc_write;
  assign pc_source  = rst_n & w_pc_source;
  assign ir_write   = rst_n & w_ir_write;
  assign mem_read   = rst_n & w_mem_read;
  assign mem_write  = rst_n & w_mem_write;
  assign i_or_d     = rst_n & w_i_or_d;
  assign reg_write  = rst_n & w_reg_write;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign illegal    = r_illegal;
  assign state      = r_state;

`ifdef MC_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cycle_count, r_retired_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      if (r_state != S_TRAP) r_cycle_count <= r_cycle_count + 1'b1;
      if (r_state != S_FETCH && w_next == S_FETCH)
        r_retired_count <= r_retired_count + 1'b1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction phase-plan model
// plus directed literal sequences and randomized instruction streams.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int P_FETCH = 0, P_DECODE = 1, P_ADDR = 2, P_MEM_LD = 3, P_MEM_ST = 4;
  localparam int P_WB_LD = 5, P_EXEC_R = 6, P_WB_R = 7, P_BR_CBZ = 8, P_BR_B = 9, P_TRAP = 10;
  localparam int C_LDUR = 0, C_STUR = 1, C_RTYPE = 2, C_CBZ = 3, C_B = 4, C_BAD = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  ALU_op, alu_src_b;
  logic        alu_src_a, reg2loc, pc_write, pc_source, ir_write, mem_read;
  logic        mem_write, i_or_d, reg_write, mem_to_reg, illegal;
  logic [3:0]  state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_count, retired_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int          m_cur = P_FETCH;
  int          m_plan[$];
  bit          m_ill = 1'b0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ALU_op     (ALU_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg2loc    (reg2loc),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .state      (state)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [10:0] op);
    logic [7:0] hi8;
    logic [5:0] hi6;
    hi8 = op[10:3];
    hi6 = op[10:5];
    if (op == 11'b11111000010) return C_LDUR;
    if (op == 11'b11111000000) return C_STUR;
    if (op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
        op == 11'b10101010000 || op == 11'b11010011011 || op == 11'b11010011010)
      return C_RTYPE;
    if (hi8 == 8'b10110100) return C_CBZ;
    if (hi6 == 6'b000101) return C_B;
    return C_BAD;
  endfunction

  function automatic logic [10:0] pick_op();
    case ($urandom_range(0, 10))
      0:       return 11'b11111000010;
      1:       return 11'b11111000000;
      2:       return 11'b10001011000;
      3:       return 11'b11001011000;
      4:       return 11'b10001010000;
      5:       return 11'b10101010000;
      6:       return 11'b11010011011;
      7:       return 11'b11010011010;
      8:       return {8'b10110100, 3'($urandom_range(0, 7))};
      9:       return {6'b000101, 5'($urandom_range(0, 31))};
      default: return 11'($urandom);
    endcase
  endfunction

  // Compare process: checks every cycle against the model, then advances it.
  initial begin
    logic [1:0] e_op, e_b;
    logic e_a, e_r2, e_pcw, e_pcs, e_ir, e_mr, e_mw, e_iod, e_rw, e_m2r;
    int nxt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst ALU_op", ALU_op, 0);     chk("rst alu_src_b", alu_src_b, 0);
        chk("rst alu_src_a", alu_src_a, 0); chk("rst pc_write", pc_write, 0);
        chk("rst ir_write", ir_write, 0); chk("rst mem_read", mem_read, 0);
        chk("rst mem_write", mem_write, 0); chk("rst reg_write", reg_write, 0);
        chk("rst state", state, P_FETCH); chk("rst illegal", illegal, 0);
`ifdef MC_PERF_COUNTERS_EN
        chk("rst cycle_count", cycle_count, 0);
        chk("rst retired_count", retired_count, 0);
`endif
        m_cur = P_FETCH; m_plan.delete(); m_ill = 1'b0; m_cyc = '0; m_ret = '0;
      end else begin
        e_op = 2'b00; e_b = 2'b00; e_a = 0; e_r2 = 0; e_pcw = 0; e_pcs = 0;
        e_ir = 0; e_mr = 0; e_mw = 0; e_iod = 0; e_rw = 0; e_m2r = 0;
        case (m_cur)
          P_FETCH:  begin e_mr = 1; e_b = 2'b01; e_ir = mem_ready; e_pcw = mem_ready; end
          P_DECODE: begin
            e_b  = 2'b11;
            e_r2 = (classify(opcode) == C_STUR) || (classify(opcode) == C_CBZ);
          end
          P_ADDR:   begin e_a = 1; e_b = 2'b10; end
          P_MEM_LD: begin e_mr = 1; e_iod = 1; end
          P_MEM_ST: begin e_mw = 1; e_iod = 1; e_r2 = 1; end
          P_WB_LD:  begin e_rw = 1; e_m2r = 1; end
          P_EXEC_R: begin e_a = 1; e_op = 2'b10; end
          P_WB_R:   e_rw = 1;
          P_BR_CBZ: begin e_r2 = 1; e_op = 2'b01; e_pcs = 1; e_pcw = zero; end
          P_BR_B:   begin e_pcs = 1; e_pcw = 1; end
          default:  ;
        endcase
        chk("state", state, m_cur);         chk("ALU_op", ALU_op, e_op);
        chk("alu_src_a", alu_src_a, e_a);   chk("alu_src_b", alu_src_b, e_b);
        chk("reg2loc", reg2loc, e_r2);      chk("pc_write", pc_write, e_pcw);
        chk("pc_source", pc_source, e_pcs); chk("ir_write", ir_write, e_ir);
        chk("mem_read", mem_read, e_mr);    chk("mem_write", mem_write, e_mw);
        chk("i_or_d", i_or_d, e_iod);       chk("reg_write", reg_write, e_rw);
        chk("mem_to_reg", mem_to_reg, e_m2r); chk("illegal", illegal, m_ill);
`ifdef MC_PERF_COUNTERS_EN
        chk("cycle_count", cycle_count, m_cyc);
        chk("retired_count", retired_count, m_ret);
`endif
        nxt = m_cur;
        case (m_cur)
          P_FETCH: if (mem_ready) nxt = P_DECODE;
          P_DECODE: begin
            case (classify(opcode))
              C_LDUR:  m_plan = '{P_ADDR, P_MEM_LD, P_WB_LD};
              C_STUR:  m_plan = '{P_ADDR, P_MEM_ST};
              C_RTYPE: m_plan = '{P_EXEC_R, P_WB_R};
              C_CBZ:   m_plan = '{P_BR_CBZ};
              C_B:     m_plan = '{P_BR_B};
              default: m_plan = '{P_TRAP};
            endcase
            nxt = m_plan.pop_front();
          end
          P_MEM_LD, P_MEM_ST: if (mem_ready) begin
            if (m_plan.size() > 0) nxt = m_plan.pop_front();
            else nxt = P_FETCH;
          end
          P_TRAP: nxt = P_TRAP;
          default: begin
            if (m_plan.size() > 0) nxt = m_plan.pop_front();
            else nxt = P_FETCH;
          end
        endcase
        if (m_cur != P_TRAP) m_cyc = m_cyc + 1;
        if (m_cur != P_FETCH && nxt == P_FETCH) m_ret = m_ret + 1;
        if (nxt == P_TRAP) m_ill = 1'b1;
        m_cur = nxt;
      end
    end
  end

  // Directed sequence: literal state per cycle plus literal strobe counts.
  task automatic run_seq(input string name, input logic [10:0] op, input logic z,
                         input logic [15:0] mr, input logic [63:0] exp_st, input int n,
                         input int exp_pcw, input int exp_rw, input int exp_mrd);
    int pcw, rw, mrd;
    logic [3:0] s;
    pcw = 0; rw = 0; mrd = 0;
    opcode = op;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      s = exp_st[4*i +: 4];
      chk({name, " seq state"}, state, s);
      pcw += int'(pc_write);
      rw  += int'(reg_write);
      mrd += int'(mem_read);
      @(posedge clk); #1;
    end
    chk({name, " pc_write cycles"}, pcw, exp_pcw);
    chk({name, " reg_write cycles"}, rw, exp_rw);
    chk({name, " mem_read cycles"}, mrd, exp_mrd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cmp=%0d bad=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int trap_cnt;
    trap_cnt = 0;
    #2;
    chk("reset state literal", state, 0);
    chk("reset alu_src_b literal", alu_src_b, 0);
    chk("reset mem_read literal", mem_read, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_seq("ADD",  11'b10001011000, 1'b0, 16'hFFFF, 64'h7610,    4, 1, 1, 1);
    run_seq("LDUR", 11'b11111000010, 1'b0, 16'h0067, 64'h5333210, 7, 1, 1, 4);
    run_seq("STUR", 11'b11111000000, 1'b0, 16'hFFFF, 64'h4210,    4, 1, 0, 1);
    run_seq("CBZ1", 11'b10110100101, 1'b1, 16'hFFFF, 64'h810,     3, 2, 0, 1);
    run_seq("CBZ0", 11'b10110100011, 1'b0, 16'hFFFF, 64'h810,     3, 1, 0, 1);
    run_seq("B",    11'b00010111011, 1'b0, 16'hFFFF, 64'h910,     3, 2, 0, 1);
    run_seq("LSR",  11'b11010011010, 1'b0, 16'hFFFE, 64'h76100,   5, 1, 1, 2);

    run_seq("BAD",  11'b00000000000, 1'b0, 16'hFFFF, 64'hAA10,    4, 1, 0, 1);
    chk("trap illegal set", illegal, 1);
    run_seq("TRAPHOLD", 11'b10001011000, 1'b1, 16'hFFFF, 64'hAAAAA, 5, 0, 0, 0);
    chk("trap illegal sticky", illegal, 1);
    do_reset();
    chk("illegal cleared by reset", illegal, 0);

    // Reset pulse while a store is waiting on memory.
    run_seq("STPRE", 11'b11111000000, 1'b0, 16'hFFFF, 64'h210, 3, 1, 0, 1);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mem_st mem_write", mem_write, 1);
    chk("mem_st state", state, P_MEM_ST);
    #2 rst_n = 1'b0;
    #1;
    chk("async mem_write drop", mem_write, 0);
    chk("async i_or_d drop", i_or_d, 0);
    chk("async state fetch", state, P_FETCH);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset state", state, P_FETCH);
    chk("post-reset mem_read", mem_read, 1);
    @(posedge clk); #1;

`ifdef MC_PERF_COUNTERS_EN
    do_reset();
    run_seq("PSTUR", 11'b11111000000, 1'b0, 16'hFFFF, 64'h4210, 4, 1, 0, 1);
    run_seq("PB",    11'b00010100001, 1'b0, 16'hFFFF, 64'h910,  3, 2, 0, 1);
    chk("perf retired_count", retired_count, 2);
    chk("perf cycle_count", cycle_count, 7);
`endif

    for (int c = 0; c < 600; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if (trap_cnt > 3 || $urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        trap_cnt = 0;
      end
      mem_ready = ($urandom_range(0, 9) < 7);
      zero      = 1'($urandom_range(0, 1));
      if (m_cur == P_FETCH) opcode = pick_op();
      if (m_cur == P_TRAP) trap_cnt++;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle LEGv8 datapath. It sequences fetch, decode, execute, memory and writeback for LDUR, STUR, CBZ, B, ADD, SUB, AND, ORR, LSL and LSR.
- Drives `ALU_op` into the ALU control decoder, plus all mux selects and write strobes.
- Supports a variable-latency instruction/data memory through a `mem_ready` handshake.

Parameters:
- `OP_WIDTH`, 11, width of the instruction opcode field (instr[31:21]).
- `CNT_WIDTH`, 32, width of the performance counters (used only with the optional feature).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  OP_WIDTH  instr[31:21] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `ALU_op`  out  2  00 add (address/PC), 01 CBZ pass-B, 10 R-type (funct from opcode)
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-extended D-imm, 11 shifted branch offset
- `reg2loc`  out  1  1 selects Rt on read port 2
- `pc_write`  out  1  PC load strobe (already qualified by `zero` for CBZ)
- `pc_source`  out  1  0 = ALU result, 1 = ALUOut register
- `ir_write`  out  1  instruction register load
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `i_or_d`  out  1  0 = PC address, 1 = ALUOut address
- `reg_write`  out  1  register file write
- `mem_to_reg`  out  1  writeback select, 1 = MDR
- `illegal`  out  1  sticky undecodable-opcode flag
- `state`  out  4  current state encoding, for debug

Behaviour:
- One clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset state:
  - state = FETCH, `illegal` = 0.
  - While `rst_n` = 0, every strobe (`pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) is forced to 0.
  - All selects are 0 and `ALU_op` = 00.
- Outputs are Moore, decoded from state. The only exceptions are `pc_write`/`ir_write` (gated by `mem_ready`) and `pc_write` in CBZ (gated by `zero`).
- Defaults in every state: all strobes 0, all selects 0.
- FETCH:
  - `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ALU_op`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stay while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- DECODE:
  - `alu_src_a`=0, `alu_src_b`=11, `ALU_op`=00 (branch target into ALUOut).
  - `reg2loc`=1 for STUR/CBZ.
  - Dispatch: LDUR/STUR→ADDR; R-type→EXEC_R; CBZ (`10110100???`)→BR_CBZ; B (`000101?????`)→BR_B; otherwise→TRAP.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALU_op`=00. Next: MEM_LD for LDUR, MEM_ST for STUR.
- MEM_LD: `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then go to WB_LD.
- MEM_ST: `mem_write`=1, `i_or_d`=1, `reg2loc`=1. Hold until `mem_ready`, then go to FETCH.
- WB_LD: `reg_write`=1, `mem_to_reg`=1, then FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `ALU_op`=10, then WB_R.
- WB_R: `reg_write`=1, `mem_to_reg`=0, then FETCH.
- BR_CBZ: `reg2loc`=1, `alu_src_b`=00, `ALU_op`=01, `pc_source`=1, `pc_write`=`zero`, then FETCH.
- BR_B: `pc_source`=1, `pc_write`=1, then FETCH.
- TRAP: all strobes 0, `illegal`=1. Remain in TRAP until reset.
- Latency with zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ/B 3. Each memory wait cycle adds 1.
- Memory request (`mem_read`/`mem_write`) is held stable while waiting. It drops in the cycle after `mem_ready`.
- `mem_ready` outside FETCH/MEM_LD/MEM_ST is ignored.
- Reset asserted mid-instruction aborts the instruction immediately; strobes drop asynchronously.

Optional Feature:
- Macro: `MC_PERF_COUNTERS_EN`.
- When defined:
  - Adds outputs `cycle_count` [CNT_WIDTH] and `retired_count` [CNT_WIDTH], both reset to 0.
  - `cycle_count` increments every cycle not in TRAP.
  - `retired_count` increments on each transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNT_WIDTH.
- When undefined: the ports and logic do not exist.

Decomposition:
- Shared package holds:
  - opcode constants (LDUR, STUR, CBZ, ADD, SUB, AND, ORR, LSL, LSR, B), with wildcard masks for CBZ/B;
  - state encoding enum (FETCH=0 … TRAP=10);
  - `ALU_op` encodings 00/01/10;
  - `alu_src_b` encodings.
- Natural sub-module: `mc_opcode_classify`. It is combinational and maps `opcode` to {is_ldur, is_stur, is_rtype, is_cbz, is_b, is_illegal}; the FSM uses it for dispatch.

Test Plan:
- ADD opcode `10001011000`, `mem_ready` tied 1 → states FETCH, DECODE, EXEC_R, WB_R; `ALU_op`=10 in EXEC_R; `reg_write`=1 exactly one cycle; back in FETCH at cycle 4.
- LDUR with `mem_ready` low 2 cycles in MEM_LD → `mem_read`/`i_or_d`=1 held 3 cycles; WB_LD `mem_to_reg`=1; 7 cycles total.
- CBZ with `zero`=1, then again with `zero`=0 → `pc_write`=1 / 0 in BR_CBZ; `pc_source`=1; `ALU_op`=01.
- Opcode `00000000000` → TRAP after DECODE; `illegal`=1 sticky; no strobes; cleared only by `rst_n`=0.
- `rst_n` pulsed low during MEM_ST with `mem_write`=1 → `mem_write` drops in the same cycle; state=FETCH after release.
- With `MC_PERF_COUNTERS_EN`: STUR then B with `mem_ready`=1 → `retired_count`=2, `cycle_count`=7.
